// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
// Contents:
//   WIDTH, NUM_REGS, ZERO_REG, ADDR_W : geometry of the register file
//   word_t, reg_addr_t                : data word and register index types
//   is_zero_reg()                     : true when an index names the hardwired zero register
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W   = 5;

    typedef logic [WIDTH-1:0]  word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    // The zero register is never written and always reads back as 0.
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return (addr == reg_addr_t'(ZERO_REG));
    endfunction

endpackage

// File: rtl/decoder_5_32.sv
// Write-side demultiplexer: turns a 5-bit register index plus an enable
// into a 32-bit one-hot select. With en low every output is low.
// Ports:
//   en     : in  1   - qualifies the decode (write strobe)
//   addr   : in  5   - register index
//   onehot : out 32  - one-hot select, all zero when en is low
module decoder_5_32
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    // One-hot decode of addr, gated by en.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/regfile_wr_demux.sv
// 32-entry x 64-bit register file between writeback (write port) and
// decode (two read ports). A single write word is steered into exactly one
// register by the 5-bit one-hot demux; reads are combinational.
// Register ZERO_REG never loads and always reads 0.
// Build option: define REGFILE_BYPASS_EN to forward wr_data to a read port
// in the same cycle when the write targets the register being read.
// Ports:
//   clk      : in  1      - rising-edge clock
//   reset    : in  1      - asynchronous active-high clear of all registers
//   wr_en    : in  1      - write strobe
//   wr_addr  : in  5      - destination register index
//   wr_data  : in  WIDTH  - word to store
//   rd_addr1 : in  5      - read port 1 index
//   rd_addr2 : in  5      - read port 2 index
//   rd_data1 : out WIDTH  - read port 1 data
//   rd_data2 : out WIDTH  - read port 2 data
module regfile_wr_demux
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  reg_addr_t rd_addr1,
    input  reg_addr_t rd_addr2,
    output word_t     rd_data1,
    output word_t     rd_data2
);

    logic [NUM_REGS-1:0] wr_onehot_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    word_t               regs_r [NUM_REGS];
    word_t               rd_word1_s;
    word_t               rd_word2_s;

    decoder_5_32 u_wr_decoder (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot_s)
    );

    // Mask the zero register's enable so it can never be loaded.
    always_comb begin
        wr_sel_s           = wr_onehot_s;
        wr_sel_s[ZERO_REG] = 1'b0;
    end

    // Register storage: async clear, load only on the selected entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel_s[i]) begin
                    regs_r[i] <= wr_data;
                end
            end
        end
    end

    // Read port 1: stored word, zero register forced to 0, optional forwarding.
    always_comb begin
        rd_word1_s = regs_r[rd_addr1];
        if (is_zero_reg(rd_addr1)) begin
            rd_word1_s = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (wr_addr == rd_addr1)) begin
            rd_word1_s = wr_data;
        end
`endif
        else begin
            rd_word1_s = regs_r[rd_addr1];
        end
    end

    // Read port 2: same selection as port 1 on its own index.
    always_comb begin
        rd_word2_s = regs_r[rd_addr2];
        if (is_zero_reg(rd_addr2)) begin
            rd_word2_s = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (wr_addr == rd_addr2)) begin
            rd_word2_s = wr_data;
        end
`endif
        else begin
            rd_word2_s = regs_r[rd_addr2];
        end
    end

    assign rd_data1 = rd_word1_s;
    assign rd_data2 = rd_word2_s;

endmodule

// File: tb/tb_regfile_wr_demux.sv
`timescale 1ns/100ps
module tb_regfile_wr_demux;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      wr_en;
    reg_addr_t wr_addr;
    word_t     wr_data;
    reg_addr_t rd_addr1;
    reg_addr_t rd_addr2;
    word_t     rd_data1;
    word_t     rd_data2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    port;
        word_t exp;
    } sb_item_t;

    sb_item_t sb[$];
    word_t    model [NUM_REGS];

    regfile_wr_demux dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Illegal stimulus monitor: wr_addr must be known whenever wr_en is high.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            total++;
            assert (!$isunknown(wr_addr)) else begin
                bad++;
                $error("FAIL wr_addr_x observed=%b required=known", wr_addr);
            end
        end
    end

    function automatic word_t model_rd(input reg_addr_t a);
        if (a == reg_addr_t'(ZERO_REG)) return '0;
        return model[a];
    endfunction

    // Pop the oldest expectation and compare it against the named port.
    task automatic pop_check();
        sb_item_t it;
        word_t    obs;
        it  = sb.pop_front();
        obs = (it.port == 1) ? rd_data1 : rd_data2;
        total++;
        assert (obs === it.exp) else begin
            bad++;
            $error("FAIL %s port%0d observed=%h expected=%h", it.tag, it.port, obs, it.exp);
        end
    endtask

    // Drive both read addresses, queue expectations from an explicit value pair.
    task automatic read_exp(input reg_addr_t a1, input reg_addr_t a2,
                            input word_t e1, input word_t e2, input string tag);
        rd_addr1 = a1;
        rd_addr2 = a2;
        sb.push_back('{tag, 1, e1});
        sb.push_back('{tag, 2, e2});
        #1;
        pop_check();
        pop_check();
    endtask

    task automatic read_pair(input reg_addr_t a1, input reg_addr_t a2, input string tag);
        read_exp(a1, a2, model_rd(a1), model_rd(a2), tag);
    endtask

    task automatic write(input logic en, input reg_addr_t a, input word_t d);
        @(negedge clk);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        if (en && a != reg_addr_t'(ZERO_REG)) model[a] = d;
        wr_en = 1'b0;
    endtask

    initial begin
        word_t fwd;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 64'd0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 64'd0;

        // Reset state on every register.
        #2;
        for (int i = 0; i < NUM_REGS; i++) read_exp(5'(i), 5'(31 - i), 64'd0, 64'd0, "reset_init");
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read.
        write(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D);
        read_exp(5'd5, 5'd4, 64'hDEADBEEF_CAFEF00D, 64'd0, "basic_wr");
        read_exp(5'd6, 5'd0, 64'd0, 64'd0, "basic_others");

        // Zero register: 0 before and after the edge of a write attempt.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read_exp(5'd31, 5'd31, 64'd0, 64'd0, "zero_pre");
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_exp(5'd31, 5'd31, 64'd0, 64'd0, "zero_post");

        // Write disabled holds the prior value.
        write(1'b1, 5'd7, 64'd64);
        write(1'b0, 5'd7, 64'd102);
        read_exp(5'd7, 5'd7, 64'd64, 64'd64, "wr_disabled");

        // Full sweep then mirrored pair reads.
        for (int i = 0; i <= 30; i++) write(1'b1, 5'(i), 64'(i * 3));
        for (int i = 0; i <= 30; i++) read_exp(5'(i), 5'(30 - i), 64'(i * 3), 64'((30 - i) * 3), "sweep");
        read_pair(5'd31, 5'd12, "sweep_model");

        // Same-cycle read/write hazard on register 10.
        write(1'b1, 5'd10, 64'd1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd10;
        wr_data = 64'd2;
`ifdef REGFILE_BYPASS_EN
        fwd = 64'd2;
`else
        fwd = 64'd1;
`endif
        read_exp(5'd10, 5'd11, fwd, 64'd33, "hazard_pre");
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model[10] = 64'd2;
        read_exp(5'd10, 5'd10, 64'd2, 64'd2, "hazard_post");

        // Mid-simulation reset with a write held active: immediate clear, reset wins.
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'h5555_AAAA_1234_5678;
        reset   = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 64'd0;
        for (int i = 0; i < NUM_REGS / 2; i++) read_pair(5'(i), 5'(31 - i), "reset_mid");
        repeat (2) @(posedge clk);
        #1;
        read_exp(5'd3, 5'd20, 64'd0, 64'd0, "reset_wins");
        @(negedge clk);
        reset = 1'b0;
        read_exp(5'd3, 5'd3, 64'd0, 64'd0, "reset_released");
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model[3] = 64'h5555_AAAA_1234_5678;
        read_pair(5'd3, 5'd4, "resume_wr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
